ahb_lite_master: RTL
====================

Name: ahb_lite_master

Overview:
- Bus master that drives the ahb3lite_bus interface into the AHB-lite slave subsystem (AHB_TOP); sits directly upstream of it.
- Converts simple single/burst commands from a local requester into pipelined AHB-lite address/data phases.
- Handles HREADY wait states, the two-cycle HRESP error response and 1 KB burst-boundary rules.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data bus width (32 or 64)
MAX_BEATS, 16, maximum beats per command

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  start address
cmd_size  in  3  HSIZE encoding
cmd_beats  in  5  beat count, 1..MAX_BEATS
wr_req  out  1  pulse: requester must present next write beat on wr_data this cycle
wr_data  in  DATA_W  write beat data
rd_valid  out  1  read beat valid
rd_data  out  DATA_W  read beat data
rd_last  out  1  final read beat
done  out  1  one-cycle command-complete pulse
err  out  1  qualifies done: command failed
HADDR  out  ADDR_W  AHB address
HWRITE  out  1  AHB direction
HSIZE  out  3  AHB size
HBURST  out  3  AHB burst type
HTRANS  out  2  AHB transfer type
HMASTLOCK  out  1  tied 0
HPROT  out  4  tied 4'b0011 (data, privileged)
HWDATA  out  DATA_W  AHB write data
HRDATA  in  DATA_W  AHB read data
HREADY  in  1  transfer ready / wait state
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Async active-low reset: HTRANS=IDLE(00), HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, cmd_ready=1, wr_req=rd_valid=rd_last=done=err=0; FSM to IDLE. Reset mid-burst abandons the command; no done.
- FSM: IDLE -> ADDR (first beat, NONSEQ) -> SEQ (remaining beats) -> LAST_DATA (final data phase) -> IDLE; ERR entered from any data phase.
- Outputs are registered, so the command-to-NONSEQ latency is 1 cycle.
- Accept: cmd_ready=1 only in IDLE. On accept, cmd_ready drops and the next cycle drives NONSEQ with HADDR=cmd_addr.
- HBURST: beats=1 -> SINGLE(000); 4 -> INCR4(011); 8 -> INCR8(101); 16 -> INCR16(111); other counts -> INCR(001).
- Address step is 1<<cmd_size. Each beat after the first is SEQ.
- Address/control advance only on cycles with HREADY=1. With HREADY=0, HADDR/HTRANS/HSIZE/HBURST/HWRITE are held stable.
- Writes: wr_req pulses in the cycle an address phase is accepted (HREADY=1). wr_data is captured into HWDATA that edge and held until that data phase completes.
- Reads: rd_valid=1 with rd_data=HRDATA in the cycle after a data phase completes with HREADY=1 & HRESP=0. rd_last is set on the final beat.
- Completion: done=1, err=0 one cycle after the last data phase completes OKAY. cmd_ready returns 1 the same cycle.
- Error handling:
  - HRESP=1 with HREADY=0 (first error cycle): next cycle drives HTRANS=IDLE and cancels all remaining beats.
  - When the second cycle (HRESP=1, HREADY=1) completes: done=1, err=1.
  - No rd_valid for the failed beat.
- Illegal commands produce done=1, err=1 one cycle after accept, with no bus activity. Illegal means any of:
  - cmd_beats=0 or >MAX_BEATS
  - 8<<cmd_size > DATA_W
  - misaligned cmd_addr
  - burst crossing a 1 KB boundary
- Back-to-back: a new command may be accepted the cycle done pulses. Its NONSEQ may overlap the previous command's final data phase only after that phase completes; no IDLE gap is required.

Test Plan:
- Single write, addr 0x100, size 2, data 0xDEADBEEF, HREADY=1 -> NONSEQ/SINGLE at 0x100, HWDATA=0xDEADBEEF next cycle, done=1 err=0.
- INCR4 read at 0x200, slave returns 1,2,3,4 -> HADDR 0x200,0x204,0x208,0x20C (NONSEQ,SEQ,SEQ,SEQ); rd_data 1..4; rd_last on 4th beat.
- INCR8 write at 0x40 with 2 wait states on beat 3 -> address/control held while HREADY=0; HWDATA stable; 8 wr_req pulses; done after beat 8.
- Error on beat 2 of INCR4 read -> HTRANS=IDLE after first HRESP cycle; only 1 rd_valid; done=1 err=1; no further SEQ.
- Illegal commands: 8-beat word burst at 0x3F0 (crosses 1 KB), and misaligned addr 0x102 with size 2 -> HTRANS stays IDLE; done=1 err=1 one cycle after accept.
- Assert HRESETn=0 during beat 3 of INCR16 -> HTRANS=IDLE immediately; cmd_ready=1; no done. A fresh command then completes normally.

Source files
------------

// File: rtl/ahb_lite_master.sv
// ahb_lite_master
// ----------------------------------------------------------------------------
// AHB-lite bus master. Turns single and burst commands from a local requester
// into pipelined AHB-lite address and data phases. It handles HREADY wait
// states, the two-cycle ERROR response and the 1 KB burst-boundary rule.
// Illegal commands are rejected without any bus activity.
//
// Ports
//   HCLK, HRESETn           bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write/addr/size/beats  command direction, start address, HSIZE, beat count
//   wr_req, wr_data         write-beat request pulse and the requester's beat data
//   rd_valid/rd_data/rd_last   read beats returned to the requester
//   done, err               completion pulse, and its failure qualifier
//   HADDR..HWDATA           AHB-lite master outputs (HMASTLOCK/HPROT are constant)
//   HRDATA, HREADY, HRESP   AHB-lite slave responses
// ----------------------------------------------------------------------------
module ahb_lite_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [4:0]        cmd_beats,
    output logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [1:0]        HTRANS,
    output logic              HMASTLOCK,
    output logic [3:0]        HPROT,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_SEQ  = 3'd2;
    localparam logic [2:0] S_LAST = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] haddr_q,    haddr_d;
    logic              hwrite_q,   hwrite_d;
    logic [2:0]        hsize_q,    hsize_d;
    logic [2:0]        hburst_q,   hburst_d;
    logic [1:0]        htrans_q,   htrans_d;
    logic [DATA_W-1:0] hwdata_q,   hwdata_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q,  rd_last_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    // Address beats still to be issued after the one currently on the bus.
    logic [4:0]        left_q,     left_d;
    // A data phase is outstanding, and whether it belongs to the final beat.
    logic              dph_q,      dph_d;
    logic              dlast_q,    dlast_d;

    logic        addr_go;
    logic        data_go;
    logic        err_first;
    logic        cmd_legal;
    logic [2:0]  burst_code;
    logic [31:0] bytes;
    logic [31:0] span;
    logic [31:0] end_off;

    // An address phase is accepted, or a data phase completes, on HREADY=1.
    // The first error cycle is the HREADY=0 half of the ERROR response.
    assign addr_go   = HREADY && (htrans_q != TR_IDLE);
    assign data_go   = HREADY && dph_q;
    assign err_first = dph_q && !HREADY && HRESP;
    assign wr_req    = addr_go && hwrite_q;

    // Legality: beat count in range, beat fits the bus, start address
    // aligned to the beat size, and the whole burst stays inside one 1 KB page.
    assign bytes     = 32'd1 << cmd_size;
    assign span      = 32'(cmd_beats) << cmd_size;
    assign end_off   = 32'(cmd_addr[9:0]) + span;
    assign cmd_legal = (cmd_beats != 5'd0)
                    && (32'(cmd_beats) <= 32'(MAX_BEATS))
                    && ((bytes << 3) <= 32'(DATA_W))
                    && ((32'(cmd_addr[9:0]) & (bytes - 32'd1)) == 32'd0)
                    && (end_off <= 32'd1024);

    // Fixed-length burst codes for 4/8/16 beats, INCR for any other length.
    always_comb begin
        case (cmd_beats)
            5'd1:    burst_code = 3'b000;
            5'd4:    burst_code = 3'b011;
            5'd8:    burst_code = 3'b101;
            5'd16:   burst_code = 3'b111;
            default: burst_code = 3'b001;
        endcase
    end

    // Next-state logic. A data phase completing and the next address phase
    // being accepted happen in the same cycle, so the data-phase update is
    // done first and the address-phase update may then re-arm dph_d.
    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        htrans_d   = htrans_q;
        hwdata_d   = hwdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        left_d     = left_q;
        dph_d      = dph_q;
        dlast_d    = dlast_q;

        if (wr_req) begin
            hwdata_d = wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal) begin
                        state_d  = S_ADDR;
                        htrans_d = TR_NONSEQ;
                        haddr_d  = cmd_addr;
                        hwrite_d = cmd_write;
                        hsize_d  = cmd_size;
                        hburst_d = burst_code;
                        left_d   = cmd_beats - 5'd1;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_ADDR, S_SEQ, S_LAST: begin
                if (err_first) begin
                    // Cancel the pending address phase and every remaining beat.
                    htrans_d = TR_IDLE;
                    left_d   = 5'd0;
                    state_d  = S_ERR;
                end else if (data_go && HRESP) begin
                    // ERROR without the leading wait cycle: still fail cleanly.
                    htrans_d = TR_IDLE;
                    left_d   = 5'd0;
                    dph_d    = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    if (data_go) begin
                        dph_d = 1'b0;
                        if (!hwrite_q) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = HRDATA;
                            rd_last_d  = dlast_q;
                        end
                        if (dlast_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    if (addr_go) begin
                        dph_d   = 1'b1;
                        dlast_d = (left_q == 5'd0);
                        if (left_q != 5'd0) begin
                            htrans_d = TR_SEQ;
                            haddr_d  = haddr_q + (ADDR_W'(1) << hsize_q);
                            left_d   = left_q - 5'd1;
                            state_d  = S_SEQ;
                        end else begin
                            htrans_d = TR_IDLE;
                            state_d  = S_LAST;
                        end
                    end
                end
            end
            S_ERR: begin
                // Second ERROR cycle: the failed beat retires, no read data.
                if (HREADY) begin
                    dph_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                htrans_d = TR_IDLE;
                dph_d    = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any command in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= 3'd0;
            hburst_q   <= 3'd0;
            htrans_q   <= TR_IDLE;
            hwdata_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            left_q     <= 5'd0;
            dph_q      <= 1'b0;
            dlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hburst_q   <= hburst_d;
            htrans_q   <= htrans_d;
            hwdata_q   <= hwdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
            left_q     <= left_d;
            dph_q      <= dph_d;
            dlast_q    <= dlast_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign err       = err_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = hburst_q;
    assign HTRANS    = htrans_q;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HWDATA    = hwdata_q;

endmodule
